// File: rtl/reg_ctx_pkg.sv
// Shared types and constants for the register context store.
package reg_ctx_pkg;

  localparam int DUMP_W    = 992;
  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = 31;
  localparam int CNT_W     = 5;
  localparam int BIT_IDX_W = 10;

  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    SNAP,
    WRITE,
    READ,
    LOAD,
    DONE
  } ctxState_t;

endpackage

// File: rtl/ctx_mem.sv
// Context storage: NUM_CTX*32 words of 32 bits, synchronous write, asynchronous read.
module ctx_mem
  import reg_ctx_pkg::*;
#(
  parameter int NUM_CTX = 4,
  parameter int ADDR_W  = $clog2(NUM_CTX) + CNT_W
) (
  input  logic              CLK,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wrData,
  output logic [WORD_W-1:0] rdData
);

  localparam int DEPTH = NUM_CTX * 32;

  logic [WORD_W-1:0] mem [DEPTH];

  // NOTE: storage arrays carry no reset so they map onto RAM; contents are undefined until written.
  always_ff @(posedge CLK) begin
    if (wrEn) mem[addr] <= wrData;
  end

  assign rdData = mem[addr];

endmodule

// File: rtl/reg_context_store.sv
// Saves/restores a 31x32-bit register file image into NUM_CTX contexts.
// Optional CTX_VALID_CHECK_EN: per-context valid bits reject restores of unsaved contexts.
module reg_context_store
  import reg_ctx_pkg::*;
#(
  parameter int NUM_CTX = 4,
  parameter int CTX_W   = $clog2(NUM_CTX)
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              SaveReq,
  input  logic              RestoreReq,
  input  logic [CTX_W-1:0]  CtxId,
  input  logic [DUMP_W-1:0] Dump,
  output logic              Save,
  output logic              Load,
  output logic [DUMP_W-1:0] LDump,
  output logic              Busy,
  output logic              Done,
  output logic              Error
);

  localparam int ADDR_W = CTX_W + CNT_W;

  ctxState_t          state;
  logic [CNT_W-1:0]   wordCnt;
  logic [CTX_W-1:0]   ctxQ;
  logic               opSave;
  logic [DUMP_W-1:0]  dumpBuf;
  logic [WORD_W-1:0]  wrData;
  logic [WORD_W-1:0]  rdData;
  logic [BIT_IDX_W-1:0] bitBase;
  logic               restoreOk;

  assign bitBase = {wordCnt, 5'b0};
  assign wrData  = dumpBuf[bitBase +: WORD_W];

  ctx_mem #(
    .NUM_CTX (NUM_CTX),
    .ADDR_W  (ADDR_W)
  ) uMem (
    .CLK    (CLK),
    .wrEn   (state == WRITE),
    .addr   ({ctxQ, wordCnt}),
    .wrData (wrData),
    .rdData (rdData)
  );

  always_ff @(posedge CLK) begin
    if (state == SNAP) dumpBuf <= Dump;
  end

`ifdef CTX_VALID_CHECK_EN
  logic [NUM_CTX-1:0] validQ;
  logic               errorQ;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      validQ <= '0;
      errorQ <= 1'b0;
    end else begin
      errorQ <= (state == IDLE) && !SaveReq && RestoreReq && !validQ[CtxId];
      if (state == IDLE && SaveReq)  validQ[CtxId] <= 1'b0;
      else if (state == DONE && opSave) validQ[ctxQ] <= 1'b1;
    end
  end

  assign restoreOk = validQ[CtxId];
  assign Error     = errorQ;
`else
  assign restoreOk = 1'b1;
  assign Error     = 1'b0;
`endif

  // NOTE: all state and registered outputs use non-blocking assignments; strobes default low each cycle.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      wordCnt <= '0;
      ctxQ    <= '0;
      opSave  <= 1'b0;
      Save    <= 1'b0;
      Load    <= 1'b0;
      Done    <= 1'b0;
      Busy    <= 1'b0;
      LDump   <= '0;
    end else begin
      Save <= 1'b0;
      Load <= 1'b0;
      Done <= 1'b0;
      case (state)
        IDLE: begin
          wordCnt <= '0;
          if (SaveReq) begin
            state  <= SNAP;
            ctxQ   <= CtxId;
            opSave <= 1'b1;
            Save   <= 1'b1;
            Busy   <= 1'b1;
          end else if (RestoreReq && restoreOk) begin
            state  <= READ;
            ctxQ   <= CtxId;
            opSave <= 1'b0;
            Busy   <= 1'b1;
          end
        end
        SNAP: begin
          state   <= WRITE;
          wordCnt <= '0;
        end
        WRITE: begin
          if (wordCnt == LAST_WORD) begin
            state   <= DONE;
            wordCnt <= '0;
            Done    <= 1'b1;
          end else begin
            wordCnt <= wordCnt + 1'b1;
          end
        end
        READ: begin
          LDump[bitBase +: WORD_W] <= rdData;
          if (wordCnt == LAST_WORD) begin
            state   <= LOAD;
            wordCnt <= '0;
            Load    <= 1'b1;
          end else begin
            wordCnt <= wordCnt + 1'b1;
          end
        end
        LOAD: begin
          state   <= DONE;
          wordCnt <= '0;
          Done    <= 1'b1;
        end
        DONE: begin
          state   <= IDLE;
          wordCnt <= '0;
          Busy    <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          wordCnt <= '0;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_context_store.sv
// Scoreboard bench for reg_context_store; CTX_VALID_CHECK_EN selects the valid-bit scenarios.
module tb_reg_context_store;
  import reg_ctx_pkg::*;

  localparam int NUM_CTX = 4;
  localparam int CTX_W   = 2;

  logic              CLK = 1'b0;
  logic              Reset = 1'b1;
  logic              SaveReq = 1'b0;
  logic              RestoreReq = 1'b0;
  logic [CTX_W-1:0]  CtxId = '0;
  logic [DUMP_W-1:0] Dump = '0;
  logic              Save, Load, Busy, Done, Error;
  logic [DUMP_W-1:0] LDump;

  reg_context_store #(.NUM_CTX(NUM_CTX), .CTX_W(CTX_W)) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .SaveReq    (SaveReq),
    .RestoreReq (RestoreReq),
    .CtxId      (CtxId),
    .Dump       (Dump),
    .Save       (Save),
    .Load       (Load),
    .LDump      (LDump),
    .Busy       (Busy),
    .Done       (Done),
    .Error      (Error)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int nChecks = 0;
  int nErrors = 0;

  typedef enum int {EV_SAVE, EV_LOAD, EV_DONE, EV_ERROR} evKind_t;
  typedef struct {
    evKind_t           kind;
    int                cycle;
    logic [DUMP_W-1:0] img;
  } expEv_t;

  expEv_t            expQ[$];
  logic [DUMP_W-1:0] model [NUM_CTX];
  bit                validModel [NUM_CTX];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic checkImage(input string tag, input logic [DUMP_W-1:0] got,
                            input logic [DUMP_W-1:0] exp);
    for (int w = 0; w < NUM_WORDS; w++)
      check($sformatf("%s_w%0d", tag, w + 1), 64'(got[w*WORD_W +: WORD_W]),
            64'(exp[w*WORD_W +: WORD_W]));
  endtask

  function automatic logic [DUMP_W-1:0] mkImg(input logic [31:0] base);
    logic [DUMP_W-1:0] r;
    r = '0;
    for (int k = 1; k <= NUM_WORDS; k++) r[(k-1)*WORD_W +: WORD_W] = base + 32'(k);
    return r;
  endfunction

  function automatic logic [DUMP_W-1:0] randImg();
    logic [DUMP_W-1:0] r;
    r = '0;
    for (int w = 0; w < NUM_WORDS; w++) r[w*WORD_W +: WORD_W] = $urandom;
    return r;
  endfunction

  task automatic popEvent(input evKind_t kind);
    expEv_t e;
    if (expQ.size() == 0) begin
      check($sformatf("unexpected_%s", kind.name()), 1, 0);
      return;
    end
    e = expQ.pop_front();
    check("event_kind", kind, e.kind);
    check($sformatf("%s_cycle", kind.name()), cyc, e.cycle);
    if (kind == EV_LOAD) checkImage("ldump", LDump, e.img);
    check("busy_at_event", Busy, kind != EV_ERROR);
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge CLK) begin
    if (!Reset) begin
      if (Save && Load) check("save_load_overlap", 1, 0);
      if (Save)  popEvent(EV_SAVE);
      if (Load)  popEvent(EV_LOAD);
      if (Done)  popEvent(EV_DONE);
      if (Error) popEvent(EV_ERROR);
    end
  end

  task automatic startSave(input int c, input logic [DUMP_W-1:0] img, input bit alsoRestore,
                           output int t);
    @(negedge CLK);
    t          = cyc;
    SaveReq    = 1'b1;
    RestoreReq = alsoRestore;
    CtxId      = CTX_W'(c);
    Dump       = img;
    expQ.push_back('{EV_SAVE, t + 1, '0});
    expQ.push_back('{EV_DONE, t + 33, '0});
    model[c]      = img;
    validModel[c] = 1'b1;
    @(negedge CLK);
    SaveReq    = 1'b0;
    RestoreReq = 1'b0;
    CtxId      = ~CtxId;
    @(negedge CLK);
    Dump = randImg();
  endtask

  task automatic startRestore(input int c, output int t);
    @(negedge CLK);
    t          = cyc;
    RestoreReq = 1'b1;
    CtxId      = CTX_W'(c);
`ifdef CTX_VALID_CHECK_EN
    if (!validModel[c]) expQ.push_back('{EV_ERROR, t + 1, '0});
    else
`endif
    begin
      expQ.push_back('{EV_LOAD, t + 32, model[c]});
      expQ.push_back('{EV_DONE, t + 33, '0});
    end
    @(negedge CLK);
    RestoreReq = 1'b0;
    CtxId      = ~CtxId;
  endtask

  task automatic waitIdle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 80 && !ok; i++) begin
      @(negedge CLK);
      ok = !Busy && (expQ.size() == 0);
    end
    if (!ok) begin
      check({tag, "_timeout"}, 1, 0);
      expQ.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int t;
    logic [DUMP_W-1:0] held;

    for (int c = 0; c < NUM_CTX; c++) begin
      validModel[c] = 1'b0;
      model[c]      = '0;
    end

    repeat (2) @(negedge CLK);
    check("rst_busy",  Busy,  0);
    check("rst_save",  Save,  0);
    check("rst_load",  Load,  0);
    check("rst_done",  Done,  0);
    check("rst_error", Error, 0);
    check("rst_ldump", 64'(|LDump), 0);
    #2 Reset = 1'b0;

    // Ascending-pattern save and restore of context 2.
    startSave(2, mkImg(32'hA000_0000), 0, t);
    waitIdle("save2");
    startRestore(2, t);
    waitIdle("restore2");

    // Independent contexts do not contaminate each other.
    startSave(0, randImg(), 0, t);
    waitIdle("save0");
    startSave(3, randImg(), 0, t);
    waitIdle("save3");
    startRestore(0, t);
    waitIdle("restore0");
    startRestore(3, t);
    waitIdle("restore3");
    startRestore(2, t);
    waitIdle("restore2b");
    held = model[2];

    // Simultaneous requests: the save wins, the restore is dropped.
    startSave(1, mkImg(32'h1100_0000), 1, t);
    waitIdle("both_req");
    checkImage("ldump_held", LDump, held);
    startRestore(1, t);
    waitIdle("restore1");

    // A restore request during WRITE is ignored.
    startSave(1, randImg(), 0, t);
    while (cyc < t + 6) @(negedge CLK);
    RestoreReq = 1'b1;
    CtxId      = 2'd0;
    @(negedge CLK);
    RestoreReq = 1'b0;
    check("busy_in_write", Busy, 1);
    waitIdle("ignored_restore");
    startRestore(1, t);
    waitIdle("restore1b");

    // Reset during WRITE cycle 10 aborts the save immediately.
    startSave(3, randImg(), 0, t);
    while (cyc < t + 11) @(negedge CLK);
    #2 Reset = 1'b1;
    #1;
    check("abort_busy",  Busy,  0);
    check("abort_save",  Save,  0);
    check("abort_load",  Load,  0);
    check("abort_done",  Done,  0);
    check("abort_error", Error, 0);
    check("abort_ldump", 64'(|LDump), 0);
    expQ.delete();
    for (int c = 0; c < NUM_CTX; c++) validModel[c] = 1'b0;
    repeat (2) @(negedge CLK);
    #2 Reset = 1'b0;
    repeat (40) @(negedge CLK);

`ifdef CTX_VALID_CHECK_EN
    startRestore(3, t);
    waitIdle("restore_aborted");
    startRestore(1, t);
    waitIdle("restore_unsaved");
    startSave(1, randImg(), 0, t);
    waitIdle("save1_after_rst");
    startRestore(1, t);
    waitIdle("restore1_after_rst");
`else
    validModel[0] = 1'b1;
    startRestore(0, t);
    waitIdle("restore0_after_rst");
`endif

    repeat (3) @(negedge CLK);
    check("final_queue_empty", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
